// File: rtl/otp_macro_rsp.sv
// Behavioural OTP macro responder: req/gnt/rvalid command port over a program-once 16-bit word array.
// Optional backdoor write port enabled by defining OTP_MACRO_RSP_BACKDOOR_EN.
module otp_macro_rsp #(
  parameter int Depth       = 64,
  parameter int IfWords     = 4,
  parameter int ReadLatency = 2,
  parameter int ProgCycles  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     otp_req_i,
  input  logic [2:0]               otp_cmd_i,
  input  logic [1:0]               otp_size_i,
  input  logic [$clog2(Depth)-1:0] otp_addr_i,
  input  logic [16*IfWords-1:0]    otp_wdata_i,
`ifdef OTP_MACRO_RSP_BACKDOOR_EN
  input  logic                     bd_we_i,
  input  logic [$clog2(Depth)-1:0] bd_addr_i,
  input  logic [15:0]              bd_wdata_i,
`endif
  output logic                     otp_gnt_o,
  output logic                     otp_rvalid_o,
  output logic [16*IfWords-1:0]    otp_rdata_o,
  output logic [2:0]               otp_err_o,
  output logic                     idle_o
);

  localparam int AW = $clog2(Depth);
  localparam int DW = 16 * IfWords;

  localparam logic [2:0] CmdRead     = 3'd0;
  localparam logic [2:0] CmdWrite    = 3'd1;
  localparam logic [2:0] CmdReadRaw  = 3'd2;
  localparam logic [2:0] CmdWriteRaw = 3'd3;
  localparam logic [2:0] CmdInit     = 3'd4;

  localparam logic [2:0] ErrNone       = 3'd0;
  localparam logic [2:0] ErrMacro      = 3'd1;
  localparam logic [2:0] ErrWriteBlank = 3'd4;

  typedef enum logic [1:0] {IdleSt, ReadSt, ProgSt, RespSt} state_e;

  state_e          state_q;
  logic [15:0]     mem_q [Depth];
  logic [AW-1:0]   addr_q;
  logic [1:0]      size_q;
  logic [DW-1:0]   wdata_q;
  logic [1:0]      k_q;
  logic [31:0]     cyc_q;
  logic [2:0]      err_q;
  logic [DW-1:0]   rdata_q;
  logic            rvalid_q;

  function automatic logic [15:0] mem_word(input logic [AW:0] idx);
    return (idx < (AW+1)'(Depth)) ? mem_q[idx[AW-1:0]] : 16'h0;
  endfunction

  function automatic logic [DW-1:0] read_words(input logic [AW-1:0] a, input logic [1:0] sz);
    logic [DW-1:0] r;
    logic [AW:0]   idx;
    r = '0;
    for (int i = 0; i < IfWords; i++) begin
      idx = {1'b0, a} + (AW+1)'(i);
      if (i <= int'(sz)) r[16*i +: 16] = mem_word(idx);
    end
    return r;
  endfunction

  function automatic logic [15:0] word_sel(input logic [DW-1:0] d, input logic [1:0] idx);
    logic [15:0] w;
    w = 16'h0;
    for (int i = 0; i < IfWords; i++) begin
      if (i == int'(idx)) w = d[16*i +: 16];
    end
    return w;
  endfunction

  logic [AW:0]  end_addr;
  logic         req_bad;
  logic         is_read;
  logic         is_write;
  logic [AW:0]  prog_addr;
  logic [15:0]  prog_old;
  logic [15:0]  prog_wword;
  logic         prog_blank_err;

  // Range check is done once at grant; a transaction wider than the interface is also rejected.
  assign end_addr  = {1'b0, otp_addr_i} + (AW+1)'(otp_size_i);
  assign is_read   = (otp_cmd_i == CmdRead)  || (otp_cmd_i == CmdReadRaw);
  assign is_write  = (otp_cmd_i == CmdWrite) || (otp_cmd_i == CmdWriteRaw);
  assign req_bad   = (end_addr > (AW+1)'(Depth - 1)) || (int'(otp_size_i) >= IfWords) ||
                     !(is_read || is_write || (otp_cmd_i == CmdInit));

  assign prog_addr      = {1'b0, addr_q} + (AW+1)'(k_q);
  assign prog_old       = mem_word(prog_addr);
  assign prog_wword     = word_sel(wdata_q, k_q);
  assign prog_blank_err = |(prog_old & ~prog_wword);

  assign otp_gnt_o    = (state_q == IdleSt) && otp_req_i;
  assign otp_rvalid_o = rvalid_q;
  assign otp_rdata_o  = rdata_q;
  assign otp_err_o    = err_q;
  assign idle_o       = (state_q == IdleSt);

  always_ff @(posedge clk_i) begin
    if (otp_gnt_o) begin
      addr_q  <= otp_addr_i;
      size_q  <= otp_size_i;
      wdata_q <= otp_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IdleSt;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= ErrNone;
      k_q      <= 2'd0;
      cyc_q    <= 32'd0;
      for (int i = 0; i < Depth; i++) mem_q[i] <= 16'h0;
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        IdleSt: begin
          if (otp_req_i) begin
            k_q     <= 2'd0;
            cyc_q   <= 32'd0;
            err_q   <= ErrNone;
            rdata_q <= '0;
            if (req_bad) begin
              err_q    <= ErrMacro;
              state_q  <= RespSt;
              rvalid_q <= 1'b1;
            end else if (is_read) begin
              if (ReadLatency == 1) begin
                rdata_q  <= read_words(otp_addr_i, otp_size_i);
                state_q  <= RespSt;
                rvalid_q <= 1'b1;
              end else begin
                state_q <= ReadSt;
              end
            end else if (is_write) begin
              state_q <= ProgSt;
            end else begin
              state_q  <= RespSt;
              rvalid_q <= 1'b1;
            end
          end
        end
        ReadSt: begin
          if (cyc_q == 32'(ReadLatency - 2)) begin
            rdata_q  <= read_words(addr_q, size_q);
            state_q  <= RespSt;
            rvalid_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        ProgSt: begin
          // Commit on the last dwell cycle; the blank error is sticky but the OR still lands.
          if (cyc_q == 32'(ProgCycles - 1)) begin
            mem_q[prog_addr[AW-1:0]] <= prog_old | prog_wword;
            if (prog_blank_err) err_q <= ErrWriteBlank;
            cyc_q <= 32'd0;
            if (k_q == size_q) begin
              state_q  <= RespSt;
              rvalid_q <= 1'b1;
            end else begin
              k_q <= k_q + 2'd1;
            end
          end else begin
            cyc_q <= cyc_q + 32'd1;
          end
        end
        RespSt:  state_q <= IdleSt;
        default: state_q <= IdleSt;
      endcase
`ifdef OTP_MACRO_RSP_BACKDOOR_EN
      // Placed last so it wins over a same-edge front-door commit.
      if (bd_we_i) mem_q[bd_addr_i] <= bd_wdata_i;
`endif
    end
  end

endmodule

// File: tb/tb_otp_macro_rsp.sv
// Bench for otp_macro_rsp: directed and random transactions against an array-based program-once model.
module tb_otp_macro_rsp;
  localparam int Depth = 64, IfWords = 4, RL = 2, PC = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req;
  logic [2:0]  cmd;
  logic [1:0]  size;
  logic [5:0]  addr;
  logic [63:0] wdata;
  logic        gnt, rvalid, idle;
  logic [63:0] rdata;
  logic [2:0]  err;
`ifdef OTP_MACRO_RSP_BACKDOOR_EN
  logic        bd_we;
  logic [5:0]  bd_addr;
  logic [15:0] bd_wdata;
`endif

  otp_macro_rsp #(.Depth(Depth), .IfWords(IfWords), .ReadLatency(RL), .ProgCycles(PC)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .otp_req_i    (req),
    .otp_cmd_i    (cmd),
    .otp_size_i   (size),
    .otp_addr_i   (addr),
    .otp_wdata_i  (wdata),
`ifdef OTP_MACRO_RSP_BACKDOOR_EN
    .bd_we_i      (bd_we),
    .bd_addr_i    (bd_addr),
    .bd_wdata_i   (bd_wdata),
`endif
    .otp_gnt_o    (gnt),
    .otp_rvalid_o (rvalid),
    .otp_rdata_o  (rdata),
    .otp_err_o    (err),
    .idle_o       (idle)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passes = 0;
  logic [15:0] mem_m [Depth];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model computes the response from the command rules, then one transaction is run on the DUT.
  task automatic do_txn(input logic [2:0] c, input logic [1:0] s, input logic [5:0] a,
                        input logic [63:0] w, input string tag);
    logic [63:0] exp_rd;
    logic [2:0]  exp_err;
    int          exp_lat, lat, base;
    bit          got, early_gnt;
    exp_rd = '0; exp_err = 3'd0; base = int'(a);
    if (c > 3'd4 || base + int'(s) > Depth - 1) begin
      exp_err = 3'd1; exp_lat = 1;
    end else if (c == 3'd0 || c == 3'd2) begin
      exp_lat = RL;
      for (int i = 0; i <= int'(s); i++) exp_rd[16*i +: 16] = mem_m[base + i];
    end else if (c == 3'd1 || c == 3'd3) begin
      exp_lat = (int'(s) + 1) * PC + 1;
      for (int i = 0; i <= int'(s); i++) begin
        logic [15:0] ww;
        ww = w[16*i +: 16];
        if ((mem_m[base + i] & ~ww) != 16'h0) exp_err = 3'd4;
        mem_m[base + i] = mem_m[base + i] | ww;
      end
    end else begin
      exp_lat = 1;
    end

    @(negedge clk_i);
    req = 1'b1; cmd = c; size = s; addr = a; wdata = w;
    #1 chk($sformatf("%s_gnt", tag), 64'(gnt), 64'd1);
    @(posedge clk_i);
    // Request stays asserted as if another command were pending: no grant may appear until Idle.
    lat = 0; got = 0; early_gnt = 0;
    while (!got && lat < 60) begin
      @(negedge clk_i);
      lat++;
      if (gnt) early_gnt = 1;
      if (rvalid) begin
        got = 1;
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk($sformatf("%s_lat", tag), 64'(lat), 64'(exp_lat));
    chk($sformatf("%s_rdata", tag), rdata, exp_rd);
    chk($sformatf("%s_err", tag), 64'(err), 64'(exp_err));
    chk($sformatf("%s_nogntbusy", tag), 64'(early_gnt), 64'd0);
    @(negedge clk_i);
    chk($sformatf("%s_pulse", tag), {62'd0, rvalid, idle}, 64'd1);
  endtask

  initial begin
    logic [2:0]  rc;
    logic [63:0] rw;
    bit          stray;
    rst_i = 1'b1; req = 1'b0; cmd = 3'd0; size = 2'd0; addr = '0; wdata = '0;
`ifdef OTP_MACRO_RSP_BACKDOOR_EN
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
`endif
    for (int i = 0; i < Depth; i++) mem_m[i] = 16'h0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_outs", {gnt, rvalid, err}, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    rst_i = 1'b0;

    do_txn(3'd0, 2'd3, 6'd5,  64'h0,      "rd_blank");
    do_txn(3'd1, 2'd0, 6'd5,  64'h00F0,   "wr_f0");
    do_txn(3'd0, 2'd0, 6'd5,  64'h0,      "rd_f0");
    do_txn(3'd1, 2'd0, 6'd5,  64'h000F,   "wr_clear");
    do_txn(3'd2, 2'd0, 6'd5,  64'h0,      "rd_ff");
    do_txn(3'd3, 2'd3, 6'd62, {4{16'hFFFF}}, "wr_oor");
    do_txn(3'd0, 2'd1, 6'd62, 64'h0,      "rd_top");
    do_txn(3'd0, 2'd0, 6'd63, 64'h0,      "rd_last");
    do_txn(3'd7, 2'd0, 6'd0,  64'h0,      "cmd_bad");
    do_txn(3'd4, 2'd0, 6'd0,  64'h0,      "cmd_init");

    // Reset in the middle of a 4-word program: no response, storage cleared.
    @(negedge clk_i);
    req = 1'b1; cmd = 3'd1; size = 2'd3; addr = 6'd10; wdata = 64'h1111_2222_3333_4444;
    @(posedge clk_i);
    #1 req = 1'b0;
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_idle", {62'd0, rvalid, idle}, 64'd1);
    rst_i = 1'b0;
    stray = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (rvalid) stray = 1;
    end
    chk("midrst_norsp", 64'(stray), 64'd0);
    for (int i = 0; i < Depth; i++) mem_m[i] = 16'h0;
    for (int i = 0; i < Depth; i += 4) do_txn(3'd0, 2'd3, 6'(i), 64'h0, $sformatf("clr%0d", i));

    for (int n = 0; n < 40; n++) begin
      rc = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      rw = {$urandom, $urandom} & {$urandom, $urandom};
      do_txn(rc, 2'($urandom_range(0, 3)), 6'($urandom_range(0, Depth - 1)), rw,
             $sformatf("rnd%0d", n));
    end

`ifdef OTP_MACRO_RSP_BACKDOOR_EN
    @(negedge clk_i);
    bd_we = 1'b1; bd_addr = 6'd9; bd_wdata = 16'hA5A5;
    @(negedge clk_i);
    bd_we = 1'b0;
    mem_m[9] = 16'hA5A5;
    do_txn(3'd0, 2'd0, 6'd9, 64'h0, "bd_rd");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
